// File: rtl/spi_peripheral.sv
// SPI target: oversamples SCLK/CS_N/COPI in the i_clk domain and exchanges one byte per 8 SCLK
// sample edges. It presents a one-byte tx holding buffer and an rx valid pulse to user logic.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_mode,
  input  logic [7:0] i_tx,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx,
  output logic       o_rx_valid,
  output logic       o_underrun,
  output logic       o_busy,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_copi,
  output logic       o_cipo,
  output logic       o_cipo_oe
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic                   cpol_q;
  logic                   cpha_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             rx_shift_q;
  logic [7:0]             tx_shift_q;
  logic [7:0]             tx_buf_q;
  logic                   buf_full_q;

  logic sclk_s, cs_s, copi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic load, tx_write;

  // Synchroniser chains plus one edge-detect stage; reset to an idle bus (CS_N high, SCLK low).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      copi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], i_copi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  // Mode decode uses the CPOL/CPHA latched at CS_N assertion.
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign tx_write   = i_tx_valid & ~buf_full_q;
  assign o_tx_ready = ~buf_full_q;
  assign o_cipo     = tx_shift_q[7];

  // Decide when the shift register takes a new byte; CS_N rise suppresses any coincident edge.
  always_comb begin
    load = 1'b0;
    if (state_q == StIdle) begin
      load = cs_fall & ~i_mode[0];
    end else begin
      load = ~cs_rise & shift_edge & (bit_cnt_q == 3'd0);
    end
  end

  // Holding buffer: a same-cycle write and load on an empty buffer leaves the new byte buffered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_buf_q   <= 8'h00;
      buf_full_q <= 1'b0;
    end else begin
      if (tx_write) tx_buf_q <= i_tx;
      buf_full_q <= tx_write | (buf_full_q & ~load);
    end
  end

  // Transfer FSM with registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      tx_shift_q <= 8'h00;
      o_rx       <= 8'h00;
      o_rx_valid <= 1'b0;
      o_underrun <= 1'b0;
      o_busy     <= 1'b0;
      o_cipo_oe  <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_underrun <= load & ~buf_full_q;
      if (load) tx_shift_q <= buf_full_q ? tx_buf_q : 8'h00;
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            cpol_q    <= i_mode[1];
            cpha_q    <= i_mode[0];
            bit_cnt_q <= 3'd0;
            state_q   <= StActive;
            o_busy    <= 1'b1;
            o_cipo_oe <= 1'b1;
          end
        end
        StActive: begin
          if (cs_rise) begin
            // Abandon any partial byte; the loaded tx byte is dropped.
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            o_busy     <= 1'b0;
            o_cipo_oe  <= 1'b0;
            tx_shift_q <= 8'h00;
          end else begin
            if (sample_edge) begin
              rx_shift_q <= {rx_shift_q[6:0], copi_s};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                o_rx       <= {rx_shift_q[6:0], copi_s};
                o_rx_valid <= 1'b1;
              end
            end
            if (shift_edge && bit_cnt_q != 3'd0) tx_shift_q <= {tx_shift_q[6:0], 1'b0};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a behavioural SPI controller drives the pins at i_clk/8.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] tx = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx;
  logic       rx_valid;
  logic       underrun;
  logic       busy;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       copi = 1'b0;
  logic       cipo;
  logic       cipo_oe;

  int vectors = 0;
  int miscompares = 0;
  int rx_cnt = 0;
  int urun_cnt = 0;
  int rx_base;
  int urun_base;
  logic [7:0] miso;

  spi_peripheral #(.SYNC_STAGES(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_mode     (mode),
    .i_tx       (tx),
    .i_tx_valid (tx_valid),
    .o_tx_ready (tx_ready),
    .o_rx       (rx),
    .o_rx_valid (rx_valid),
    .o_underrun (underrun),
    .o_busy     (busy),
    .i_sclk     (sclk),
    .i_cs_n     (cs_n),
    .i_copi     (copi),
    .o_cipo     (cipo),
    .o_cipo_oe  (cipo_oe)
  );

  always #5 clk = ~clk;

  // Count cycles in which each pulse output is high.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_cnt++;
    if (underrun === 1'b1) urun_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {7'd0, obs}, {7'd0, exp});
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic half_bit();
    repeat (4) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    for (int n = 0; n < 64 && tx_ready !== 1'b1; n++) @(negedge clk);
    chk1("tx_ready_wait", tx_ready, 1'b1);
    tx       = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_begin(input logic [1:0] m);
    mode = m;
    sclk = m[1];
    repeat (4) @(negedge clk);
    cs_n = 1'b0;
    if (m[0]) half_bit();
  endtask

  task automatic cs_end(input logic [1:0] m);
    if (!m[0]) half_bit();
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Controller side of nbits bit times, MSB first; returns bits read from CIPO.
  task automatic xfer(input logic [1:0] m, input logic [7:0] mosi, input int nbits,
                      output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        copi = mosi[7-i];
        half_bit();
        got  = {got[6:0], cipo};
        sclk = ~sclk;
        half_bit();
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        copi = mosi[7-i];
        half_bit();
        got  = {got[6:0], cipo};
        sclk = ~sclk;
        half_bit();
      end
    end
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_rx", rx, 8'h00);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_cipo", cipo, 1'b0);
    chk1("rst_cipo_oe", cipo_oe, 1'b0);
    chk1("rst_tx_ready", tx_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: mode 0, buffer 0xA5, rx 0x3C; the 8th trailing edge reloads from an empty buffer
    rx_base = rx_cnt; urun_base = urun_cnt;
    push_tx(8'hA5);
    chk1("t1_ready_full", tx_ready, 1'b0);
    cs_begin(2'd0);
    xfer(2'd0, 8'h3C, 8, miso);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_oe", cipo_oe, 1'b1);
    cs_end(2'd0);
    chk("t1_miso", miso, 8'hA5);
    chk("t1_rx", rx, 8'h3C);
    chk_int("t1_rx_pulses", rx_cnt - rx_base, 1);
    chk_int("t1_underruns", urun_cnt - urun_base, 1);
    chk1("t1_oe_idle", cipo_oe, 1'b0);
    chk1("t1_busy_idle", busy, 1'b0);

    // 2: modes 1..3, buffer 0x81, rx 0x7E; CPHA=0 modes also reload once at the byte end
    for (int m = 1; m < 4; m++) begin
      rx_base = rx_cnt; urun_base = urun_cnt;
      push_tx(8'h81);
      cs_begin(m[1:0]);
      xfer(m[1:0], 8'h7E, 8, miso);
      chk1("t2_oe_active", cipo_oe, 1'b1);
      cs_end(m[1:0]);
      chk("t2_miso", miso, 8'h81);
      chk("t2_rx", rx, 8'h7E);
      chk_int("t2_rx_pulses", rx_cnt - rx_base, 1);
      chk_int("t2_underruns", urun_cnt - urun_base, m[0] ? 0 : 1);
      chk1("t2_oe_idle", cipo_oe, 1'b0);
    end

    // 3: three bytes in one CS with refills
    rx_base = rx_cnt; urun_base = urun_cnt;
    push_tx(8'h11);
    cs_begin(2'd0);
    push_tx(8'h22);
    xfer(2'd0, 8'hA1, 8, miso);
    chk("t3_miso0", miso, 8'h11);
    push_tx(8'h33);
    chk("t3_rx0", rx, 8'hA1);
    xfer(2'd0, 8'hB2, 8, miso);
    chk("t3_miso1", miso, 8'h22);
    chk("t3_rx1", rx, 8'hB2);
    xfer(2'd0, 8'hC4, 8, miso);
    chk("t3_miso2", miso, 8'h33);
    cs_end(2'd0);
    chk("t3_rx2", rx, 8'hC4);
    chk_int("t3_rx_pulses", rx_cnt - rx_base, 3);
    chk_int("t3_underruns", urun_cnt - urun_base, 1);

    // 4: empty buffer at CS_N fall sends 0x00; another underrun at the byte end
    rx_base = rx_cnt; urun_base = urun_cnt;
    cs_begin(2'd0);
    repeat (4) @(negedge clk);
    chk_int("t4_underrun_at_cs", urun_cnt - urun_base, 1);
    xfer(2'd0, 8'h69, 8, miso);
    cs_end(2'd0);
    chk("t4_miso", miso, 8'h00);
    chk("t4_rx", rx, 8'h69);
    chk_int("t4_rx_pulses", rx_cnt - rx_base, 1);
    chk_int("t4_underruns", urun_cnt - urun_base, 2);

    // 5: CS_N rises after 5 bits of 0xF0, then a clean 0x55 byte
    rx_base = rx_cnt; urun_base = urun_cnt;
    push_tx(8'h77);
    cs_begin(2'd0);
    xfer(2'd0, 8'hF0, 5, miso);
    cs_end(2'd0);
    chk_int("t5_no_pulse", rx_cnt - rx_base, 0);
    chk("t5_rx_held", rx, 8'h69);
    chk_int("t5_no_underrun", urun_cnt - urun_base, 0);
    push_tx(8'hAA);
    cs_begin(2'd0);
    xfer(2'd0, 8'h55, 8, miso);
    cs_end(2'd0);
    chk("t5_miso", miso, 8'hAA);
    chk("t5_rx", rx, 8'h55);
    chk_int("t5_rx_pulses", rx_cnt - rx_base, 1);

    // 6: reset asserted after 4 bits, then a full 0xC3 byte
    push_tx(8'h5A);
    cs_begin(2'd0);
    xfer(2'd0, 8'hC3, 4, miso);
    chk1("t6_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_oe", cipo_oe, 1'b0);
    chk1("t6_busy", busy, 1'b0);
    chk("t6_rx", rx, 8'h00);
    chk1("t6_cipo", cipo, 1'b0);
    chk1("t6_ready", tx_ready, 1'b1);
    chk1("t6_rx_valid", rx_valid, 1'b0);
    chk1("t6_underrun", underrun, 1'b0);
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rx_base = rx_cnt;
    push_tx(8'h5A);
    cs_begin(2'd0);
    xfer(2'd0, 8'hC3, 8, miso);
    cs_end(2'd0);
    chk("t6_miso", miso, 8'h5A);
    chk("t6_rx_after", rx, 8'hC3);
    chk_int("t6_rx_pulses", rx_cnt - rx_base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
